// File: rtl/lsp_expand_range_pkg.sv
// Shared constants, state encoding and 16-bit saturation helper for the LSP
// spacing enforcer.
package lsp_expand_range_pkg;

  localparam int GAP1 = 10;
  localparam int GAP2 = 5;
  localparam int NC   = 5;
  localparam int M    = 10;

  localparam int unsigned DATA_W = 16;
  localparam logic [10:0] RELSPWED_BUF = 11'd2040;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_PREV = 3'd1,
    ST_RD_CUR  = 3'd2,
    ST_CALC    = 3'd3,
    ST_WR_PREV = 3'd4,
    ST_WR_CUR  = 3'd5,
    ST_DONE    = 3'd6,
    ST_SKIP    = 3'd7
  } state_t;

  // Clip a 17-bit two's complement value into the 16-bit range.
  function automatic logic [15:0] sat16(input logic [16:0] x);
    logic [15:0] r;
    if (x[16] != x[15]) r = x[16] ? 16'h8000 : 16'h7fff;
    else                r = x[15:0];
    return r;
  endfunction

endpackage

// File: rtl/lsp_gap_tmp.sv
// Saturating spacing arithmetic: t = shr(sat_add(sat_sub(prev,cur),gap),1),
// plus the saturated update values written back to buf[j-1] and buf[j].
module lsp_gap_tmp
  import lsp_expand_range_pkg::*;
(
  input  logic [15:0] prev,
  input  logic [15:0] cur_rd,
  input  logic [15:0] gap,
  input  logic [15:0] cur,
  input  logic [15:0] tmp,
  output logic [15:0] t,
  output logic [15:0] prev_upd,
  output logic [15:0] cur_upd
);

  logic [15:0] diff;
  logic [15:0] sum;

  always_comb begin
    diff     = sat16({prev[15], prev} - {cur_rd[15], cur_rd});
    sum      = sat16({diff[15], diff} + {gap[15], gap});
    t        = {sum[15], sum[15:1]};
    prev_upd = sat16({prev[15], prev} - {tmp[15], tmp});
    cur_upd  = sat16({cur[15], cur} + {tmp[15], tmp});
  end

endmodule

// File: rtl/lsp_expand_range.sv
// In-place LSP spacing enforcer over buf[jFirst-1..jLast] in scratch memory,
// forwarding the updated buf[j] into the next iteration instead of re-reading it.
module lsp_expand_range
  import lsp_expand_range_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] BUF_ADDR = ADDR_W'(RELSPWED_BUF),
  parameter int unsigned       IDX_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       gap,
  input  logic [IDX_W-1:0]  jFirst,
  input  logic [IDX_W-1:0]  jLast,
  input  logic [31:0]       memIn,
  output logic [31:0]       memOut,
  output logic [ADDR_W-1:0] memReadAddr,
  output logic [ADDR_W-1:0] memWriteAddr,
  output logic              memWriteEn,
  output logic              busy,
  output logic              done
);

  state_t state, state_nxt;

  logic [IDX_W-1:0] j, jlast_q, j_prev_idx;
  logic [15:0]      gap_q, prev, cur, tmp;
  logic             first;
  logic [15:0]      mem_data, t, prev_upd, cur_upd;
  logic [15:0]      unused_mem_hi;
  logic             t_pos, range_ok;
  state_t           loop_nxt;

  assign mem_data      = memIn[15:0];
  assign unused_mem_hi = memIn[31:16];
  assign j_prev_idx    = j - IDX_W'(1);
  assign t_pos         = !t[15] && (t != 16'd0);
  assign range_ok      = (jFirst != '0) && (jFirst <= jLast);
  assign loop_nxt      = (j == jlast_q) ? ST_DONE : ST_RD_CUR;

  lsp_gap_tmp u_gap_tmp (
    .prev     (prev),
    .cur_rd   (mem_data),
    .gap      (gap_q),
    .cur      (cur),
    .tmp      (tmp),
    .t        (t),
    .prev_upd (prev_upd),
    .cur_upd  (cur_upd)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and state-decoded memory/handshake outputs
  always_comb begin
    state_nxt    = state;
    memReadAddr  = '0;
    memWriteAddr = '0;
    memOut       = '0;
    memWriteEn   = 1'b0;
    busy         = (state != ST_IDLE);
    done         = 1'b0;
    case (state)
      ST_IDLE:    if (start) state_nxt = range_ok ? ST_RD_PREV : ST_SKIP;
      // Empty range still takes two cycles so latency stays 2 + 2n + 2w.
      ST_SKIP:    state_nxt = ST_DONE;
      ST_RD_PREV: begin
        memReadAddr = BUF_ADDR + ADDR_W'(j_prev_idx);
        state_nxt   = ST_RD_CUR;
      end
      ST_RD_CUR: begin
        memReadAddr = BUF_ADDR + ADDR_W'(j);
        state_nxt   = ST_CALC;
      end
      ST_CALC:    state_nxt = t_pos ? ST_WR_PREV : loop_nxt;
      // Write strobe is dropped in the very cycle reset is raised.
      ST_WR_PREV: begin
        memWriteAddr = BUF_ADDR + ADDR_W'(j_prev_idx);
        memOut       = {{16{prev_upd[15]}}, prev_upd};
        memWriteEn   = !reset;
        state_nxt    = ST_WR_CUR;
      end
      ST_WR_CUR: begin
        memWriteAddr = BUF_ADDR + ADDR_W'(j);
        memOut       = {{16{cur_upd[15]}}, cur_upd};
        memWriteEn   = !reset;
        state_nxt    = loop_nxt;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Operand latches, index and forwarded prev/cur/tmp datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      j       <= '0;
      jlast_q <= '0;
      gap_q   <= '0;
      prev    <= '0;
      cur     <= '0;
      tmp     <= '0;
      first   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          gap_q   <= gap;
          jlast_q <= jLast;
          j       <= jFirst;
        end
        ST_RD_PREV: first <= 1'b1;
        ST_RD_CUR: if (first) begin
          prev  <= mem_data;
          first <= 1'b0;
        end
        ST_CALC: begin
          cur <= mem_data;
          if (t_pos) begin
            tmp <= t;
          end else begin
            prev <= mem_data;
            j    <= j + IDX_W'(1);
          end
        end
        ST_WR_CUR: begin
          prev <= cur_upd;
          j    <= j + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
